// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin adder arbiter and its
// sibling schedulers.
package adder_arb_pkg;

    localparam int ADD_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 cout;
        logic                 of;
    } add_rsp_t;

    // Tag width for n requesters; a single-bit tag is kept as the floor.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request, shared-adder and response signals of the adder arbiter.
// slave = arbiter side, master = requesters/adder/consumer side.
interface adder_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int ID_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;

    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_cin;
    logic [WIDTH-1:0]         add_sum;
    logic                     add_cout;
    logic                     add_of;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic                     rsp_of;
    logic [15:0]              ovf_count;

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        input  add_sum, add_cout, add_of,
        input  rsp_ready,
        output req_ready,
        output add_a, add_b, add_cin,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_of,
        output ovf_count
    );

    modport master (
        output req_valid, req_a, req_b, req_cin,
        output add_sum, add_cout, add_of,
        output rsp_ready,
        input  req_ready,
        input  add_a, add_b, add_cin,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_of,
        input  ovf_count
    );

endinterface

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or above
// i_ptr, wrapping modulo NUM_REQ. Shared with the multiplier scheduler.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = ID_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters,
// with a single registered response slot. Optional: ADDER_ARB_OVF_STATS_EN.
//
// state | meaning
// IDLE  | response slot empty
// HOLD  | response slot holds a result awaiting rsp_ready
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = ADD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    adder_rr_arbiter_if.slave  bus
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    add_rsp_t           r_rsp;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_slot_free;
    logic               w_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt = HOLD;
        end else if (r_state == HOLD && bus.rsp_ready) begin
            w_state_nxt = IDLE;
        end
    end

    // The slot drains and refills in the same cycle, so a consumer that is
    // always ready sees one result per clock.
    always_comb begin
        w_slot_free   = (r_state == IDLE) | bus.rsp_ready;
        w_hs          = w_any & w_slot_free & ~rst;
        bus.req_ready = w_grant & {NUM_REQ{w_slot_free & ~rst}};
        bus.rsp_valid = (r_state == HOLD);
    end

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (w_hs) begin
            bus.add_a   = bus.req_a[w_idx*WIDTH +: WIDTH];
            bus.add_b   = bus.req_b[w_idx*WIDTH +: WIDTH];
            bus.add_cin = bus.req_cin[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_hs) begin
            r_rsp.sum  <= ADD_WIDTH'(bus.add_sum);
            r_rsp.cout <= bus.add_cout;
            r_rsp.of   <= bus.add_of;
            r_id       <= w_idx;
            r_ptr      <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
        end
    end

    assign bus.rsp_id   = r_id;
    assign bus.rsp_sum  = WIDTH'(r_rsp.sum);
    assign bus.rsp_cout = r_rsp.cout;
    assign bus.rsp_of   = r_rsp.of;

`ifdef ADDER_ARB_OVF_STATS_EN
    logic [15:0] r_ovf_count;

    // Counts overflowed results as they leave the slot; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (r_state == HOLD && bus.rsp_ready && r_rsp.of &&
                     r_ovf_count != 16'hFFFF) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`else
    assign bus.ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural model of the
// external 32-bit adder.
module tb_adder_rr_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    adder_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    adder_rr_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External adder.
    logic [32:0] w_full;
    assign w_full       = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};
    assign bus.add_sum  = w_full[31:0];
    assign bus.add_cout = w_full[32];
    assign bus.add_of   = (bus.add_a[31] == bus.add_b[31]) && (w_full[31] != bus.add_a[31]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_cin[i]        = c;
    endtask

    logic [31:0] ea [4];
    logic [31:0] es [4];
    logic        ec [4];
    logic [15:0] exp_ovf;
    int          id;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef ADDER_ARB_OVF_STATS_EN
        exp_ovf = 16'd3;
`else
        exp_ovf = 16'd0;
`endif
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;

        // Reset: req_ready held low even with a valid request and ready consumer.
        set_req(0, 32'h1, 32'h1, 1'b0);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        tick();
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_id",    64'(bus.rsp_id),    64'h0);
        chk("rst_sum",   64'(bus.rsp_sum),   64'h0);
        chk("rst_cout",  64'(bus.rsp_cout),  64'h0);
        chk("rst_of",    64'(bus.rsp_of),    64'h0);
        chk("rst_ovf",   64'(bus.ovf_count), 64'h0);

        // Round robin from ptr=0, all four valid, consumer always ready.
        ea[0] = 32'h0000_0100; es[0] = 32'h0000_0101; ec[0] = 1'b0;
        ea[1] = 32'h0000_0200; es[1] = 32'h0000_0202; ec[1] = 1'b0;
        ea[2] = 32'hFFFF_FFFF; es[2] = 32'hFFFF_FFFE; ec[2] = 1'b1;
        ea[3] = 32'h0000_0400; es[3] = 32'h0000_0404; ec[3] = 1'b0;
        set_req(0, 32'h0000_0100, 32'h0000_0001, 1'b0);
        set_req(1, 32'h0000_0200, 32'h0000_0002, 1'b0);
        set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        set_req(3, 32'h0000_0400, 32'h0000_0003, 1'b1);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << id));
            chk("rr_add_a", 64'(bus.add_a), 64'(ea[id]));
            tick();
            chk("rr_valid", 64'(bus.rsp_valid), 64'h1);
            chk("rr_id",    64'(bus.rsp_id),    64'(id));
            chk("rr_sum",   64'(bus.rsp_sum),   64'(es[id]));
            chk("rr_cout",  64'(bus.rsp_cout),  64'(ec[id]));
            chk("rr_of",    64'(bus.rsp_of),    64'h0);
        end
        bus.req_valid = '0;
        #1;
        chk("idle_add_a", 64'(bus.add_a), 64'h0);
        tick();
        chk("drain_valid", 64'(bus.rsp_valid), 64'h0);

        // Lone requester 0 with ptr=1: still granted; signed overflow case.
        set_req(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        bus.req_valid = 4'b0001;
        #1;
        chk("one_ready", 64'(bus.req_ready), 64'h1);
        tick();
        chk("one_valid", 64'(bus.rsp_valid), 64'h1);
        chk("one_id",    64'(bus.rsp_id),    64'h0);
        chk("one_sum",   64'(bus.rsp_sum),   64'hFFFF_FFFE);
        chk("one_cout",  64'(bus.rsp_cout),  64'h0);
        chk("one_of",    64'(bus.rsp_of),    64'h1);
        bus.req_valid = '0;
        tick();

        // Backpressure with requester 1 held.
        set_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 64'(bus.req_ready), 64'h2);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 64'(bus.req_ready), 64'h0);
            tick();
            chk("bp_valid", 64'(bus.rsp_valid), 64'h1);
            chk("bp_id",    64'(bus.rsp_id),    64'h1);
            chk("bp_sum",   64'(bus.rsp_sum),   64'h7FFF_FFFF);
            chk("bp_cout",  64'(bus.rsp_cout),  64'h1);
            chk("bp_of",    64'(bus.rsp_of),    64'h1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release", 64'(bus.req_ready), 64'h2);
        tick();
        chk("bp_refill", 64'(bus.rsp_valid), 64'h1);
        bus.req_valid = '0;
        tick();
        chk("bp_empty", 64'(bus.rsp_valid), 64'h0);

        // Lone requester 2 granted on every free cycle (ptr ends at 3).
        bus.req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("lone2_ready", 64'(bus.req_ready), 64'h4);
            tick();
            chk("lone2_id", 64'(bus.rsp_id), 64'h2);
        end

        // Wrap: ptr=3 with 0 and 3 valid -> 3 then 0.
        bus.req_valid = 4'b1001;
        #1;
        chk("wrap_ready3", 64'(bus.req_ready), 64'h8);
        tick();
        chk("wrap_id3",  64'(bus.rsp_id),  64'h3);
        chk("wrap_sum3", 64'(bus.rsp_sum), 64'h0000_0404);
        chk("wrap_ready0", 64'(bus.req_ready), 64'h1);
        tick();
        chk("wrap_id0",  64'(bus.rsp_id),  64'h0);
        chk("wrap_sum0", 64'(bus.rsp_sum), 64'hFFFF_FFFE);
        bus.req_valid = '0;
        tick();

        // Reset while a result is held.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        tick();
        chk("mid_hold", 64'(bus.rsp_valid), 64'h1);
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("mid_valid", 64'(bus.rsp_valid), 64'h0);
        chk("mid_sum",   64'(bus.rsp_sum),   64'h0);
        chk("mid_id",    64'(bus.rsp_id),    64'h0);
        bus.req_valid = 4'b1111;
        #1;
        chk("mid_ptr0", 64'(bus.req_ready), 64'h1);
        bus.req_valid = '0;
        #1;

        // Overflow statistics: three overflow results, then 123+123.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ovf_rst", 64'(bus.ovf_count), 64'h0);
        set_req(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        tick();
        tick();
`ifdef ADDER_ARB_OVF_STATS_EN
        chk("ovf_one", 64'(bus.ovf_count), 64'h1);
`else
        chk("ovf_one", 64'(bus.ovf_count), 64'h0);
`endif
        tick();
        chk("ovf_third_of", 64'(bus.rsp_of), 64'h1);
        set_req(0, 32'd123, 32'd123, 1'b0);
        #1;
        tick();
        chk("ovf_sum246", 64'(bus.rsp_sum), 64'd246);
        chk("ovf_of0",    64'(bus.rsp_of),  64'h0);
        chk("ovf_after3", 64'(bus.ovf_count), 64'(exp_ovf));
        bus.req_valid = '0;
        tick();
        tick();
        chk("ovf_final", 64'(bus.ovf_count), 64'(exp_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
